// File: rtl/serial_receive_pkg.sv
// Shared link definitions for the serial receiver: framing levels, data width and FSM encodings.
// The same constants describe the line as seen by the transmit end.
package serial_receive_pkg;

    localparam int   SER_DATA_BITS  = 8;
    localparam logic SER_START_BIT  = 1'b0;
    localparam logic SER_GUARD_BIT  = 1'b0;
    localparam logic SER_IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_START) || (st == ST_DATA) || (st == ST_GUARD);
    endfunction

endpackage

// File: rtl/serial_receive_rx_sync.sv
// rx_sync: STAGES-deep synchroniser for the asynchronous serial line.
// Flops reset to the idle level so a reset never looks like a start bit.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/serial_receive.sv
// serial_receive: deframes start / D7..D0 / guard frames from rxd into bytes on a valid/ready port.
// Optional macro RX_GUARD_CHECK_EN: a guard sample of 1 pulses frame_err and drops the byte.
module serial_receive
    import serial_receive_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       enable,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF_INT = (CLKS_PER_BIT > 1) ? (CLKS_PER_BIT / 2 - 1) : 0;
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_INT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          tick, sample_guard, guard_bad, commit, accept;

    rx_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    // With one clock per bit the counter idles at zero, so every clock is a sample point.
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        sample_guard = 1'b0;
        if (!enable) begin
            state_d   = ST_HUNT;
            shreg_d   = '0;
            bit_cnt_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (rxs == SER_IDLE_LEVEL) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (rxs == SER_START_BIT) begin
                        if (CLKS_PER_BIT == 1) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_START;
                            cnt_d   = HALF_LOAD;
                        end
                    end
                end
                ST_START: begin
                    if (tick) begin
                        cnt_d   = FULL_LOAD;
                        state_d = (rxs == SER_START_BIT) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt_d     = FULL_LOAD;
                        shreg_d   = {shreg_q[SER_DATA_BITS-2:0], rxs};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_GUARD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        sample_guard = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

`ifdef RX_GUARD_CHECK_EN
    assign guard_bad = sample_guard && (rxs != SER_GUARD_BIT);
`else
    assign guard_bad = 1'b0;
`endif
    assign commit = sample_guard && !guard_bad;

    // Handshake: data is stable while data_valid=1 until a cycle with data_valid && data_ready.
    // A commit in the accept cycle loads the next byte without a bubble.
    assign accept = valid_q && data_ready;

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = guard_bad;
        if (commit) begin
            data_d    = shreg_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !accept;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign busy       = is_busy(state_q);

endmodule

// File: tb/tb_serial_receive.sv
// Self-checking bench for serial_receive: scoreboarded byte stream on a 1-clk/bit instance,
// plus a 4-clk/bit instance for false-start rejection. Honours RX_GUARD_CHECK_EN.
module tb_serial_receive;

    logic       clk = 1'b0;
    logic       rst_n, rxd, enable, data_ready;
    logic [7:0] data;
    logic       data_valid, overrun, frame_err, busy;

    logic       rxd4, enable4, ready4;
    logic [7:0] data4;
    logic       data_valid4, overrun4, frame_err4, busy4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ov_seen = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    int ready_mode = 1;
    int v4_cnt = 0;
    logic [7:0] v4_data = '0;

    logic [7:0] exp_q[$];

    serial_receive u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .enable     (enable),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    serial_receive #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd4),
        .enable     (enable4),
        .data       (data4),
        .data_valid (data_valid4),
        .data_ready (ready4),
        .overrun    (overrun4),
        .frame_err  (frame_err4),
        .busy       (busy4)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // consumer ready driver
    initial begin
        data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_ready = 1'b0;
                1:       data_ready = 1'b1;
                default: data_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // driver tasks
    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        rxd = b;
    endtask

    // Reference: a frame carries its payload byte; it is delivered unless the guard is
    // checked and bad, in which case one frame error is expected instead.
    task automatic send_frame(input logic [7:0] b, input logic g, input int gap);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(g);
`ifdef RX_GUARD_CHECK_EN
        if (g) fe_exp++;
        else exp_q.push_back(b);
`else
        exp_q.push_back(b);
`endif
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    task automatic send_bit4(input logic b);
        @(posedge clk);
        #1;
        rxd4 = b;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor: a new byte is presented when valid rises, follows an accept,
    // or replaces an unaccepted byte (overrun)
    logic       prev_valid = 1'b0;
    logic       prev_accept = 1'b0;
    logic [7:0] prev_data = '0;
    logic       mon_new;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_accept = 1'b0;
        end else begin
            mon_new = data_valid && (!prev_valid || prev_accept || overrun);
            if (mon_new) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual=%0h required=none", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("data", 32'(data), 32'(mon_exp));
                end
                check("overrun", 32'(overrun), 32'(prev_valid && !prev_accept));
            end else if (prev_valid && !prev_accept) begin
                check("valid_held", 32'(data_valid), 32'd1);
                if (data_valid) check("data_stable", 32'(data), 32'(prev_data));
            end
            if (overrun) ov_seen++;
            if (frame_err) fe_seen++;
            prev_valid  = data_valid;
            prev_accept = data_valid && data_ready;
            prev_data   = data;
        end
    end

    always @(negedge clk) begin
        if (rst_n && data_valid4) begin
            v4_cnt++;
            v4_data = data4;
        end
    end

    initial begin
        int tg, lat, vcnt, ov0, v40;
        rst_n = 1'b0;
        rxd = 1'b1;
        enable = 1'b0;
        rxd4 = 1'b1;
        enable4 = 1'b1;
        ready4 = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (4) send_bit(1'b1);

        // 1: single frame, latency and one-cycle valid with ready=1
        send_frame(8'hA5, 1'b0, 0);
        tg = cyc;
        lat = -1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            rxd = 1'b1;
            @(negedge clk);
            if (data_valid) begin
                if (lat < 0) lat = cyc - tg;
                vcnt++;
            end
        end
        check("latency", 32'(lat), 32'd3);
        check("valid_one_clk", 32'(vcnt), 32'd1);

        // 2: back-to-back frames into a stalled consumer
        ready_mode = 0;
        repeat (3) send_bit(1'b1);
        ov0 = ov_seen;
        send_frame(8'h3C, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 4);
        @(negedge clk);
        check("overrun_pulses", 32'(ov_seen - ov0), 32'd1);
        check("overwrite_data", 32'(data), 32'hC3);
        check("overwrite_valid", 32'(data_valid), 32'd1);
        ready_mode = 1;
        repeat (3) send_bit(1'b1);
        @(negedge clk);
        check("accept_clears", 32'(data_valid), 32'd0);

        // 3: held byte survives link drop; re-enable while line is low must hunt
        ready_mode = 0;
        send_frame(8'h96, 1'b0, 3);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (4) send_bit(1'b1);
        @(negedge clk);
        check("held_valid", 32'(data_valid), 32'd1);
        check("held_data", 32'(data), 32'h96);
        ready_mode = 1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (3) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        rxd = 1'b0;
        repeat (3) send_bit(1'b0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (6) send_bit(1'b0);
        @(negedge clk);
        check("hunt_not_busy", 32'(busy), 32'd0);
        repeat (3) send_bit(1'b1);
        send_frame(8'h5A, 1'b0, 3);
        wait_drain("drain_t3");

        // 4: bad guard bit, then a good frame
        send_frame(8'h55, 1'b1, 2);
        send_frame(8'h24, 1'b0, 4);
        wait_drain("drain_t4");
        check("frame_err_count", 32'(fe_seen), 32'(fe_exp));

        // 5: asynchronous reset mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data), 32'd0);
        check("async_rst_valid", 32'(data_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);
        send_frame(8'h81, 1'b0, 3);
        wait_drain("drain_t5");

        // random traffic: random bytes, gaps (0 = back-to-back), guards and consumer stalls
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 3)));
        end
        repeat (3) send_bit(1'b1);
        ready_mode = 1;
        wait_drain("drain_random");

        // 6: 4 clks/bit, one-clock glitch is a false start, then a clean frame
        v40 = v4_cnt;
        @(posedge clk);
        #1;
        rxd4 = 1'b0;
        @(posedge clk);
        #1;
        rxd4 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_no_byte", 32'(v4_cnt - v40), 32'd0);
        send_bit4(1'b0);
        for (int i = 7; i >= 0; i--) send_bit4(v4_data_pattern(i));
        send_bit4(1'b0);
        @(posedge clk);
        #1;
        rxd4 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("n4_byte_count", 32'(v4_cnt - v40), 32'd1);
        check("n4_data", 32'(v4_data), 32'h0F);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_frame_err", 32'(fe_seen), 32'(fe_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic v4_data_pattern(input int i);
        logic [7:0] b;
        b = 8'h0F;
        return b[i];
    endfunction

endmodule
